// File: rtl/reg_writeback.sv
// Register-file write-back buffer: valid/ready intake, ALU/load select, FIFO, one write per cycle.
// Define REG_WRITEBACK_BYPASS_EN to compile in the operand forwarding lookup.
module reg_writeback #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_reg,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_mem,
   input  logic              in_memtoreg,
   input  logic              in_regwrite,
   output logic [ADDR_W-1:0] writereg,
   output logic [DATA_W-1:0] writedata,
   output logic              regwrite,
   output logic [$clog2(DEPTH):0] count,
   input  logic [ADDR_W-1:0] readreg1,
   input  logic [ADDR_W-1:0] readreg2,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd1_data,
   output logic [DATA_W-1:0] fwd2_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] writereg_q;
   logic [DATA_W-1:0] writedata_q;
   logic              regwrite_q;
   logic              accept, push, pop;

   // Ready depends only on state and flush, never on a same-cycle pop.
   assign in_ready = (count_q < CW'(DEPTH)) && !flush;
   assign accept   = in_valid && in_ready;
   assign push     = accept && in_regwrite && (in_reg != '0);
   assign pop      = (count_q != '0) && !flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= in_reg;
         data_q[wr_ptr_q] <= in_memtoreg ? in_mem : in_alu;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         regwrite_q <= pop;
         if (pop) begin
            writereg_q  <= addr_q[rd_ptr_q];
            writedata_q <= data_q[rd_ptr_q];
         end
      end
   end

   assign writereg  = writereg_q;
   assign writedata = writedata_q;
   assign regwrite  = regwrite_q;
   assign count     = count_q;

`ifdef REG_WRITEBACK_BYPASS_EN
   // Scan oldest to youngest so the last match wins: output register first, then FIFO order.
   function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] ra);
      logic              hit;
      logic [DATA_W-1:0] d;
      logic [PW-1:0]     idx;
      hit = 1'b0;
      d   = '0;
      if (ra != '0) begin
         if (regwrite_q && (writereg_q == ra)) begin
            hit = 1'b1;
            d   = writedata_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == ra)) begin
               hit = 1'b1;
               d   = data_q[idx];
            end
         end
      end
      return {hit, d};
   endfunction

   always_comb begin
      {fwd1_hit, fwd1_data} = lookup(readreg1);
      {fwd2_hit, fwd2_data} = lookup(readreg2);
   end
`else
   logic unused_readreg;
   assign unused_readreg = ^{readreg1, readreg2};
   assign fwd1_hit  = 1'b0;
   assign fwd2_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: stimulus queues expected writes, a monitor checks each strobe.
module tb_reg_writeback;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, in_ready, in_memtoreg, in_regwrite;
   logic [ADDR_W-1:0] in_reg, writereg, readreg1, readreg2;
   logic [DATA_W-1:0] in_alu, in_mem, writedata, fwd1_data, fwd2_data;
   logic              regwrite, fwd1_hit, fwd2_hit;
   logic [CW-1:0]     count;

   int n_chk  = 0;
   int n_fail = 0;
   logic [ADDR_W+DATA_W-1:0] sb [$];

   always #5 clk = ~clk;

   reg_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg),
      .in_alu(in_alu), .in_mem(in_mem), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
      .writereg(writereg), .writedata(writedata), .regwrite(regwrite), .count(count),
      .readreg1(readreg1), .readreg2(readreg2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (!reset && regwrite) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: got reg %0d data 0x%0h expected none", writereg, writedata);
         end else begin
            logic [ADDR_W+DATA_W-1:0] e;
            e = sb.pop_front();
            chk("sb_writereg", 64'(writereg), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
            chk("sb_writedata", 64'(writedata), 64'(e[DATA_W-1:0]));
         end
      end
   end

   // Drive one offer at the negedge; it is sampled at the following posedge.
   task automatic offer(input logic [ADDR_W-1:0] rg, input logic [DATA_W-1:0] alu,
                        input logic [DATA_W-1:0] mem, input logic m2r, input logic rw,
                        input logic expect_out, output logic acc);
      @(negedge clk);
      in_valid = 1'b1; in_reg = rg; in_alu = alu; in_mem = mem;
      in_memtoreg = m2r; in_regwrite = rw; flush = 1'b0;
      #1;
      acc = in_ready;
      if (acc && rw && rg != '0 && expect_out)
         sb.push_back({rg, m2r ? mem : alu});
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_reg = '0; in_alu = '0; in_mem = '0;
      in_memtoreg = 1'b0; in_regwrite = 1'b0; readreg1 = '0; readreg2 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_count", 64'(count), 0);
      chk("rst_regwrite", 64'(regwrite), 0);
      chk("rst_writereg", 64'(writereg), 0);
      chk("rst_writedata", 64'(writedata), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_fwd1_hit", 64'(fwd1_hit), 0);
      reset = 1'b0;

      // Single ALU result: strobe exactly one cycle after acceptance, for one cycle.
      offer(5'd8, 32'h1234, 32'hDEAD, 1'b0, 1'b1, 1'b1, acc);
      chk("single_acc", 64'(acc), 1);
      idle();
      chk("single_pre_regwrite", 64'(regwrite), 0);
      chk("single_pre_count", 64'(count), 1);
      idle();
      chk("single_regwrite", 64'(regwrite), 1);
      chk("single_writereg", 64'(writereg), 8);
      chk("single_writedata", 64'(writedata), 64'h1234);
      idle();
      chk("single_post_regwrite", 64'(regwrite), 0);
      chk("single_hold_writereg", 64'(writereg), 8);

      // Load result selected by memtoreg.
      offer(5'd8, 32'h5555, 32'hCAFE, 1'b1, 1'b1, 1'b1, acc);
      idle();
      idle();
      chk("mem_regwrite", 64'(regwrite), 1);
      chk("mem_writedata", 64'(writedata), 64'hCAFE);
      idle();

      // Filtered offers: handshake completes, nothing queued.
      offer(5'd0, 32'hAAAA, 32'h0, 1'b0, 1'b1, 1'b1, acc);
      chk("filter_r0_acc", 64'(acc), 1);
      offer(5'd9, 32'hBBBB, 32'h0, 1'b0, 1'b0, 1'b1, acc);
      chk("filter_norw_acc", 64'(acc), 1);
      idle();
      chk("filter_count", 64'(count), 0);
      idle();
      chk("filter_regwrite", 64'(regwrite), 0);

      // Back-to-back stream across pointer wrap; order checked by the monitor.
      for (int i = 0; i < DEPTH + 3; i++) begin
         offer(ADDR_W'(i + 1), DATA_W'(32'h100 + i), 32'h0, 1'b0, 1'b1, 1'b1, acc);
         chk("stream_acc", 64'(acc), 1);
      end
      repeat (4) idle();
      chk("stream_count", 64'(count), 0);
      chk("stream_drained", 64'(sb.size()), 0);

`ifdef REG_WRITEBACK_BYPASS_EN
      offer(5'd5, 32'h11, 32'h0, 1'b0, 1'b1, 1'b1, acc);
      offer(5'd5, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1, acc);
      @(negedge clk);
      in_valid = 1'b0; readreg1 = 5'd5; readreg2 = 5'd0;
      #1;
      chk("byp_fwd1_hit", 64'(fwd1_hit), 1);
      chk("byp_fwd1_data", 64'(fwd1_data), 64'h22);
      chk("byp_fwd2_hit", 64'(fwd2_hit), 0);
      idle();
      chk("byp_outreg_hit", 64'(fwd1_hit), 1);
      chk("byp_outreg_data", 64'(fwd1_data), 64'h22);
      idle();
      idle();
      chk("byp_drained_hit", 64'(fwd1_hit), 0);
`else
      offer(5'd5, 32'h11, 32'h0, 1'b0, 1'b1, 1'b1, acc);
      @(negedge clk);
      in_valid = 1'b0; readreg1 = 5'd5; readreg2 = 5'd5;
      #1;
      chk("nobyp_fwd1_hit", 64'(fwd1_hit), 0);
      chk("nobyp_fwd1_data", 64'(fwd1_data), 0);
      chk("nobyp_fwd2_hit", 64'(fwd2_hit), 0);
      idle();
      idle();
`endif
      readreg1 = '0; readreg2 = '0;

      // Flush with an entry queued and an offer pending: both discarded.
      offer(5'd3, 32'h33, 32'h0, 1'b0, 1'b1, 1'b0, acc);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; in_reg = 5'd4; in_alu = 32'h44; in_regwrite = 1'b1;
      #1;
      chk("flush_in_ready", 64'(in_ready), 0);
      chk("flush_pre_count", 64'(count), 1);
      idle();
      chk("flush_count", 64'(count), 0);
      chk("flush_regwrite", 64'(regwrite), 0);
      idle();
      chk("flush_after_regwrite", 64'(regwrite), 0);

      // Asynchronous reset in the middle of a drain.
      offer(5'd6, 32'h66, 32'h0, 1'b0, 1'b1, 1'b0, acc);
      offer(5'd7, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0, acc);
      @(posedge clk);
      #2;
      chk("middrain_regwrite", 64'(regwrite), 1);
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("arst_regwrite", 64'(regwrite), 0);
      chk("arst_count", 64'(count), 0);
      chk("arst_writereg", 64'(writereg), 0);
      chk("arst_writedata", 64'(writedata), 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_in_ready", 64'(in_ready), 1);
      idle();
      idle();
      chk("arst_after_regwrite", 64'(regwrite), 0);
      chk("arst_after_count", 64'(count), 0);
      chk("final_sb_empty", 64'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
